univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the next generation of the team's fixed 4-bit right-shift register. It adds configurable width, parallel load, left/right logical shift, rotate and arithmetic right shift, plus multi-step shift commands with busy/done handshaking. It sits between a control FSM, which issues start/mode/amount commands, and serial or parallel datapaths that consume `q`, `sout_r` and `sout_l`.

## Interface
- `WIDTH`, default 8: register width in bits; must be at least 2.
- `CNT_W`, default `$clog2(WIDTH)+1`: width of the shift-amount field, sized so that values 0..WIDTH are representable.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `start`  in  1: command strobe; sampled only in IDLE.
- `mode`  in  3: command type; encodings are listed under Operation.
- `amount`  in  CNT_W: number of single-bit steps for shift/rotate modes.
- `sin`  in  1: serial input bit; sampled on every shift step.
- `pin`  in  WIDTH: parallel load data.
- `q`  out  WIDTH: register contents.
- `sout_r`  out  1: combinational `q[0]`.
- `sout_l`  out  1: combinational `q[WIDTH-1]`.
- `busy`  out  1: high while a multi-step command is in progress.
- `done`  out  1: one-cycle pulse when a command completes.

## Operation
- Mode encodings:
  - 0: hold.
  - 1: parallel load.
  - 2: shift right; `sin` enters the MSB.
  - 3: shift left; `sin` enters the LSB.
  - 4: rotate right; `q[0]` moves to the MSB.
  - 5: rotate left.
  - 6: arithmetic right shift; the MSB is replicated and `sin` is ignored.
  - 7: reserved; behaves exactly as hold.
- FSM has two states: IDLE and RUN.
- IDLE with `start`=0: `q` holds its value; `done`=0.
- IDLE with `start`=1, mode 1: `q` <= `pin` at the same edge; stay in IDLE; `done`=1 for the next cycle.
- IDLE with `start`=1, mode 0 or 7, or any shift mode with `amount`=0: `q` unchanged; stay in IDLE; `done`=1 for the next cycle.
- IDLE with `start`=1, modes 2-6 with `amount`=N≥1: latch mode and N into internal registers; `q` unchanged at this edge; go to RUN.
- RUN: exactly one step per edge using the latched mode. The internal counter decrements on each step. When the step that brings the counter to 0 occurs, go to IDLE and assert `done` for the following cycle.
- `sin` is sampled live at each step edge; it is not latched at start.
- While in RUN, `start`, `mode`, `amount` and `pin` are ignored. A new command is accepted only in IDLE, including the cycle in which `done` is high.
- `amount` greater than WIDTH executes literally. For shifts the register fills with `sin` (or the sign bit in mode 6); rotates wrap modulo WIDTH.
- Async reset, including mid-command: `q`=0, `busy`=0, `done`=0, state=IDLE, counter=0. Any command in progress is aborted and no `done` is produced.

## Timing
- Reset values: `q`=0, `busy`=0, `done`=0; therefore `sout_r`=0 and `sout_l`=0.
- `busy` is a registered output and equals 1 exactly while in RUN.
- Shift of N steps, start accepted at edge k:
  - `busy` is 1 from after edge k until after edge k+N.
  - Steps occur at edges k+1 through k+N.
  - `done` is high in the cycle after edge k+N.
  - Latency from start to `done` is N+1 cycles.
- Load, hold, reserved mode and `amount`=0: `done` is high in the cycle after edge k; `busy` stays 0 throughout.
- `done` is never high for more than one cycle unless back-to-back zero-latency commands are issued.
- Back-to-back commands: a start accepted in the `done` cycle proceeds with no idle gap.
- `sout_r` and `sout_l` follow `q` combinationally with no added latency.

## Test plan
All scenarios use WIDTH=8.
- Reset then load: hold `rst`=0, then release; `start`, mode=1, `pin`=8'hA5 -> `q`=8'hA5 after one edge; `done` pulses once; `busy` stays 0.
- Shift right: load 8'h00; mode=2, N=4, `sin` sequence 1,0,0,0 -> `q`=8'h10 after 4 steps; `busy` high for 4 cycles; `done` arrives 5 cycles after start.
- Rotate left: load 8'h81; mode=5, N=3 -> `q`=8'h0C; then mode=4, N=3 -> `q`=8'h81.
- Arithmetic right: load 8'h90; mode=6, N=2 -> `q`=8'hE4; `sin` held at 0 throughout has no effect.
- Edge cases:
  - mode=3, N=0 -> immediate `done`, `q` unchanged.
  - N=10 shift-left of 8'hFF with `sin`=0 -> `q`=8'h00.
  - `start` asserted while `busy` -> ignored.
- Mid-command reset: start mode=2, N=6; drive `rst`=0 asynchronously after 2 steps -> `q`=0, `busy`=0 immediately; no `done` pulse follows.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_if
//   Command and data bundle for the universal shift register.
//
//   Command side (driven by the controller, master modport):
//     start   - command strobe, honoured only while the register is idle
//     mode    - command type (hold/load/shift/rotate/arith-shift/reserved)
//     amount  - number of single-bit steps for shift/rotate modes
//     sin     - serial input bit, sampled live on every shift step
//     pin     - parallel load data
//
//   Result side (driven by the register, slave modport):
//     q       - register contents
//     sout_r  - q[0], combinational
//     sout_l  - q[WIDTH-1], combinational
//     busy    - high while a multi-step command is running
//     done    - one-cycle completion pulse
// -----------------------------------------------------------------------------
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             sin;
    logic [WIDTH-1:0] pin;

    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amount, sin, pin,
        input  q, sout_r, sout_l, busy, done
    );

    modport slave (
        input  start, mode, amount, sin, pin,
        output q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register with parallel load, logical
//   left/right shift, rotate left/right and arithmetic right shift. Shift and
//   rotate commands run for 'amount' single-bit steps, one per clock, with a
//   busy/done handshake toward the issuing controller.
//
//   Parameters:
//     WIDTH  - register width in bits (>= 2)
//     CNT_W  - width of the step-count field; holds 0..WIDTH
//
//   Ports:
//     clk    - clock, rising edge active
//     rst    - asynchronous reset, active low
//     bus    - command/result bundle (slave side), see univ_shift_reg_if
// -----------------------------------------------------------------------------
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    univ_shift_reg_if.slave bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_LOAD = 3'd1,
        M_SHR  = 3'd2,
        M_SHL  = 3'd3,
        M_ROR  = 3'd4,
        M_ROL  = 3'd5,
        M_ASR  = 3'd6,
        M_RSVD = 3'd7
    } mode_e;

    state_e           state, state_n;
    mode_e            run_mode, run_mode_n;
    mode_e            cmd_mode;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] q, q_n, q_step;
    logic             done, done_n;
    logic             busy;

    assign cmd_mode = mode_e'(bus.mode);

    // Single-step result for the latched command; sin is taken live.
    always_comb begin
        q_step = q;
        case (run_mode)
            M_SHR:   q_step = {bus.sin, q[WIDTH-1:1]};
            M_SHL:   q_step = {q[WIDTH-2:0], bus.sin};
            M_ROR:   q_step = {q[0], q[WIDTH-1:1]};
            M_ROL:   q_step = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ASR:   q_step = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_step = q;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_n    = state;
        run_mode_n = run_mode;
        cnt_n      = cnt;
        q_n        = q;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (cmd_mode)
                        M_LOAD: begin
                            q_n    = bus.pin;
                            done_n = 1'b1;
                        end
                        M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: begin
                            if (bus.amount == '0) begin
                                done_n = 1'b1;
                            end else begin
                                run_mode_n = cmd_mode;
                                cnt_n      = bus.amount;
                                state_n    = RUN;
                            end
                        end
                        default: done_n = 1'b1;
                    endcase
                end
            end

            RUN: begin
                q_n   = q_step;
                cnt_n = cnt - CNT_W'(1);
                // The step that empties the counter is the last one.
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            run_mode <= M_HOLD;
            cnt      <= '0;
            q        <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            run_mode <= run_mode_n;
            cnt      <= cnt_n;
            q        <= q_n;
            done     <= done_n;
            busy     <= (state_n == RUN);
        end
    end

    assign bus.q      = q;
    assign bus.sout_r = q[0];
    assign bus.sout_l = q[WIDTH-1];
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
//   Scoreboard bench for univ_shift_reg (WIDTH=8). The stimulus process issues
//   commands and pushes the expected result and completion cycle; a separate
//   monitor pops on every done pulse and also checks busy each cycle.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    typedef struct {
        logic [W-1:0] q;
        int           due;
        string        name;
    } exp_t;

    logic clk;
    logic rst;

    univ_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t         sb[$];
    int           cyc     = 0;
    int           busy_lo = 0;
    int           busy_hi = 0;
    int           tests   = 0;
    int           fails   = 0;
    logic [W-1:0] model_q = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of a whole command, computed bit by bit from where each output
    // bit originates after n steps.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] q0, input logic [2:0] m,
                                                input int n, input logic [W-1:0] p,
                                                input logic [15:0] s);
        logic [W-1:0] r;
        int src;
        if (m == 3'd1) return p;
        if (m == 3'd0 || m == 3'd7 || n == 0) return q0;
        r = q0;
        for (int i = 0; i < W; i++) begin
            case (m)
                3'd2: begin src = i + n; r[i] = (src < W)  ? q0[src] : s[src - W]; end
                3'd3: begin src = i - n; r[i] = (src >= 0) ? q0[src] : s[n - i - 1]; end
                3'd4: r[i] = q0[(i + n) % W];
                3'd5: r[i] = q0[(i - (n % W) + W) % W];
                default: ;
            endcase
        end
        if (m == 3'd6) r = $unsigned($signed(q0) >>> n);
        return r;
    endfunction

    // Called #1 after a rising edge with the DUT idle (or in its done cycle).
    task automatic do_cmd(input string name, input logic [2:0] m, input logic [CW-1:0] n,
                          input logic [W-1:0] p, input logic [15:0] sbits, input bit noise);
        int   k;
        int   lat;
        exp_t e;
        k   = cyc + 1;
        lat = (m >= 3'd2 && m <= 3'd6) ? int'(n) : 0;
        e.q    = ref_result(model_q, m, int'(n), p, sbits);
        e.due  = k + lat;
        e.name = name;
        sb.push_back(e);
        busy_lo = k;
        busy_hi = k + lat;
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.amount = n;
        bus.pin    = p;
        bus.sin    = 1'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int j = 0; j < lat; j++) begin
            bus.sin = sbits[j];
            if (noise) begin
                bus.start  = 1'($urandom);
                bus.mode   = 3'($urandom);
                bus.amount = CW'($urandom);
                bus.pin    = W'($urandom);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        model_q   = e.q;
    endtask

    // Monitor: busy every cycle, and result/timing on each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            chk("busy", W'(bus.busy), W'(cyc >= busy_lo && cyc < busy_hi));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_done_cycle"}, W'(cyc), W'(e.due));
                    chk({e.name, "_q"}, bus.q, e.q);
                    chk({e.name, "_sout_r"}, W'(bus.sout_r), W'(e.q[0]));
                    chk({e.name, "_sout_l"}, W'(bus.sout_l), W'(e.q[W-1]));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                tests++;
                fails++;
                $display("FAIL %s_missing_done: got no done expected done at cycle %0d", sb[0].name, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = '0;
        bus.amount = '0;
        bus.sin    = 1'b0;
        bus.pin    = '0;

        #2;
        chk("reset_q", bus.q, '0);
        chk("reset_busy", W'(bus.busy), '0);
        chk("reset_done", W'(bus.done), '0);
        chk("reset_sout_r", W'(bus.sout_r), '0);
        chk("reset_sout_l", W'(bus.sout_l), '0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        do_cmd("load_a5",   3'd1, CW'(0),  8'hA5, 16'h0000, 1'b0);
        do_cmd("load_00",   3'd1, CW'(0),  8'h00, 16'h0000, 1'b0);
        do_cmd("shr4",      3'd2, CW'(4),  8'h00, 16'h0001, 1'b0);
        do_cmd("load_81",   3'd1, CW'(0),  8'h81, 16'h0000, 1'b0);
        do_cmd("rol3",      3'd5, CW'(3),  8'h00, 16'hFFFF, 1'b0);
        do_cmd("ror3",      3'd4, CW'(3),  8'h00, 16'h0000, 1'b0);
        do_cmd("load_90",   3'd1, CW'(0),  8'h90, 16'h0000, 1'b0);
        do_cmd("asr2",      3'd6, CW'(2),  8'h00, 16'h0000, 1'b0);
        do_cmd("shl0",      3'd3, CW'(0),  8'h00, 16'hFFFF, 1'b0);
        do_cmd("load_ff",   3'd1, CW'(0),  8'hFF, 16'h0000, 1'b0);
        do_cmd("shl10",     3'd3, CW'(10), 8'h00, 16'h0000, 1'b0);
        do_cmd("hold",      3'd0, CW'(5),  8'h3C, 16'hFFFF, 1'b0);
        do_cmd("reserved",  3'd7, CW'(5),  8'h3C, 16'hFFFF, 1'b0);
        do_cmd("load_c3",   3'd1, CW'(0),  8'hC3, 16'h0000, 1'b0);
        do_cmd("busy_noise", 3'd2, CW'(5), 8'h00, 16'h0015, 1'b1);

        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            do_cmd("rand", 3'($urandom_range(0, 7)), CW'($urandom_range(0, 15)),
                   W'($urandom), 16'($urandom), 1'b1);
        end

        // Abort a running command with an asynchronous reset.
        do_cmd("load_3c", 3'd1, CW'(0), 8'h3C, 16'h0000, 1'b0);
        busy_lo    = cyc + 1;
        busy_hi    = cyc + 7;
        bus.start  = 1'b1;
        bus.mode   = 3'd2;
        bus.amount = CW'(6);
        bus.sin    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst     = 1'b0;
        busy_lo = 0;
        busy_hi = 0;
        model_q = '0;
        #1;
        chk("midreset_q", bus.q, '0);
        chk("midreset_busy", W'(bus.busy), '0);
        chk("midreset_done", W'(bus.done), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        do_cmd("post_reset_ror1", 3'd4, CW'(1), 8'h00, 16'h0000, 1'b0);
        do_cmd("post_reset_load", 3'd1, CW'(0), 8'h5A, 16'h0000, 1'b0);

        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
        @(negedge clk); #1;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
